// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with a byte FIFO in front of the shifter.
// Bytes are queued with tx_send and go out LSB first behind a start bit, followed by
// STOP_BITS stop bits. Frames that are already queued are sent back to back with no
// idle gap between them.
module uart_tx_fifo #(
    parameter int CLK_DIV   = 104,
    parameter int FIFO_AW   = 4,
    parameter int STOP_BITS = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         tx_byte,
    input  logic               tx_send,
    output logic               tx_ready,
    output logic               tx,
    output logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow
);

    localparam int                 DEPTH     = 1 << FIFO_AW;
    localparam int                 CNT_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [FIFO_AW:0]   LVL_FULL  = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LVL_ZERO  = {(FIFO_AW + 1){1'b0}};
    localparam logic [FIFO_AW:0]   LVL_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
    localparam logic [2:0]         STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_tx;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic               r_overflow;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [2:0]         w_bit_nxt;
    logic [2:0]         w_bit_inc;
    logic [7:0]         w_shift_nxt;
    logic               w_tx_nxt;
    logic               w_cnt_end;
    logic               w_pop;
    logic               w_push;
    logic               w_ready;
    logic               w_has_data;

    assign w_ready    = (r_level != LVL_FULL);
    assign w_push     = tx_send && w_ready;
    assign w_has_data = (r_level != LVL_ZERO);
    assign w_cnt_end  = (r_cnt == CNT_MAX);
    assign w_bit_inc  = r_bit + 3'd1;

    // Next-state, baud counter, bit index, shifter and line value for the frame sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = CNT_ZERO;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;

        // The baud counter runs only while a frame is on the line.
        if (r_state != S_IDLE) begin
            w_cnt_nxt = w_cnt_end ? CNT_ZERO : (r_cnt + CNT_ONE);
        end else begin
            w_cnt_nxt = CNT_ZERO;
        end

        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_has_data) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_cnt_end) begin
                    w_tx_nxt    = r_shift[0];
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_DATA: begin
                if (w_cnt_end) begin
                    if (r_bit == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_bit_nxt   = 3'd0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_tx_nxt  = r_shift[w_bit_inc];
                        w_bit_nxt = w_bit_inc;
                    end
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_STOP: begin
                // r_bit counts stop bits here; the last one chains straight into the next frame.
                if (w_cnt_end) begin
                    if (r_bit == STOP_LAST) begin
                        w_bit_nxt = 3'd0;
                        if (w_has_data) begin
                            w_pop       = 1'b1;
                            w_shift_nxt = r_mem[r_rd_ptr];
                            w_tx_nxt    = 1'b0;
                            w_state_nxt = S_START;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_bit_nxt = w_bit_inc;
                    end
                end else begin
                    w_state_nxt = S_STOP;
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_bit_nxt   = 3'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset abandons any partial frame and releases the line high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // FIFO storage; contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_byte;
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr   <= {FIFO_AW{1'b0}};
            r_rd_ptr   <= {FIFO_AW{1'b0}};
            r_level    <= LVL_ZERO;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (tx_send && !w_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign tx         = r_tx;
    assign tx_ready   = w_ready;
    assign tx_busy    = (r_state != S_IDLE) || w_has_data;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;

endmodule
